// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter: iterative radix-2 multiplier / restoring divider with private adders.
// Define IBEX_MULTDIV_ITER_EARLY_EXIT_EN to let multiplies leave ITER once the remaining |B| is zero.
module ibex_multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    input  logic             result_ready_i,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] OP_MUL = 2'b00, OP_MULH = 2'b01, OP_DIV = 2'b10, OP_REM = 2'b11;

    typedef enum logic [2:0] {IDLE, ABS, ITER, SIGN, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]         op_q, smode_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier, quo, rem;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic               accept, div_zero, is_div, iter_last, sign_a, sign_b;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod_sum;
    logic [WIDTH:0]     div_sh, div_diff;

    assign accept   = valid_i & ready_o;
    assign div_zero = op_i[1] & (op_b_i == '0);
    assign is_div   = op_q[1];
    assign sign_a   = smode_q[0] & a_q[WIDTH-1];
    assign sign_b   = smode_q[1] & b_q[WIDTH-1];
    assign a_abs    = sign_a ? -a_q : a_q;
    assign b_abs    = sign_b ? -b_q : b_q;
    assign prod_sum = acc + mcand;
    // mplier doubles as the divisor during division; it only shifts for multiplies
    assign div_sh   = {rem, quo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mplier};
`ifdef IBEX_MULTDIV_ITER_EARLY_EXIT_EN
    assign iter_last = (cnt == LAST) | (~is_div & (mplier[WIDTH-1:1] == '0));
`else
    assign iter_last = (cnt == LAST);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (kill_i) state_nxt = IDLE;
        else begin
            unique case (state)
                IDLE:    if (accept) state_nxt = div_zero ? DONE : ABS;
                ABS:     state_nxt = ITER;
                ITER:    if (iter_last) state_nxt = SIGN;
                SIGN:    state_nxt = DONE;
                DONE:    if (result_ready_i) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o  = (state == IDLE) & ~kill_i;
        busy_o   = state != IDLE;
        valid_o  = state == DONE;
        result_o = state != DONE   ? '0 :
                   op_q == OP_MUL  ? acc[WIDTH-1:0] :
                   op_q == OP_MULH ? acc[2*WIDTH-1:WIDTH] :
                   op_q == OP_DIV  ? quo : rem;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            smode_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q    <= op_i;
                    smode_q <= signed_mode_i;
                    a_q     <= op_a_i;
                    b_q     <= op_b_i;
                    // preloaded divide-by-zero answer; ABS overwrites it otherwise
                    quo     <= '1;
                    rem     <= op_a_i;
                end
                ABS: begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a_abs};
                    mplier <= b_abs;
                    quo    <= a_abs;
                    rem    <= '0;
                    cnt    <= '0;
                    neg    <= (op_q == OP_REM) ? sign_a : sign_a ^ sign_b;
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        rem <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        if (mplier[0]) acc <= prod_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                SIGN: if (neg) begin
                    if (!is_div)      acc <= -acc;
                    else if (op_q[0]) rem <= -rem;
                    else              quo <= -quo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// tb_ibex_multdiv_iter: scoreboard bench for the iterative multiply/divide unit.
module tb_ibex_multdiv_iter;
    logic        clk = 0, rst_i = 1, kill_i = 0, valid_i = 0, result_ready_i = 1;
    logic [1:0]  op_i = 0, signed_mode_i = 0;
    logic [31:0] op_a_i = 0, op_b_i = 0, result_o;
    logic        ready_o, valid_o, busy_o;

    ibex_multdiv_iter #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .kill_i(kill_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .result_o(result_o), .valid_o(valid_o), .result_ready_i(result_ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

`ifdef IBEX_MULTDIV_ITER_EARLY_EXIT_EN
    localparam int L_B1 = 4, L_B3 = 5;
`else
    localparam int L_B1 = 35, L_B3 = 35;
`endif

    typedef struct {logic [31:0] res; int cyc; string name;} exp_t;
    typedef struct {logic [31:0] act; logic [31:0] exp; string name;} sig_t;
    exp_t exp_q[$];
    sig_t sig_q[$];
    int cyc = 0, checks = 0, errors = 0;
    logic prev_valid = 0;
    logic [31:0] held = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        sig_t s;
        while (sig_q.size() > 0) begin
            s = sig_q.pop_front();
            cmp(s.name, s.act, s.exp);
        end
        if (valid_o && !prev_valid) begin
            if (exp_q.size() == 0) cmp("unexpected_valid", 32'(valid_o), 32'd0);
            else begin
                e = exp_q.pop_front();
                cmp({e.name, "_result"}, result_o, e.res);
                cmp({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
            held = result_o;
        end else if (valid_o) cmp("hold_result", result_o, held);
        prev_valid = valid_o;
    end

    task automatic probe(string name, logic [31:0] act, logic [31:0] exp);
        sig_q.push_back('{act, exp, name});
    endtask

    task automatic drive(string name, logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp, int lat, bit push);
        @(negedge clk);
        if (push) exp_q.push_back('{exp, cyc + lat, name});
        op_i = op; signed_mode_i = sm; op_a_i = a; op_b_i = b; valid_i = 1;
        probe({name, "_ready"}, 32'(ready_o), 32'd1);
        @(negedge clk);
        valid_i = 0; op_i = ~op; signed_mode_i = ~sm; op_a_i = 32'hA5A5_5A5A; op_b_i = 0;
    endtask

    task automatic run(string name, logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, int lat, int stall);
        bit seen = 0;
        result_ready_i = (stall == 0);
        drive(name, op, sm, a, b, exp, lat, 1);
        for (int i = 0; i < 100 && !seen; i++) begin
            if (valid_o) seen = 1;
            else @(negedge clk);
        end
        probe({name, "_seen"}, 32'(seen), 32'd1);
        if (seen && stall > 0) begin
            repeat (stall) @(negedge clk);
            probe({name, "_stall_valid"}, 32'(valid_o), 32'd1);
            result_ready_i = 1;
        end
        @(negedge clk);
        probe({name, "_retired"}, 32'(valid_o), 32'd0);
        result_ready_i = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_i = 0;
        #1;
        probe("rst_ready", 32'(ready_o), 32'd1);
        probe("rst_valid", 32'(valid_o), 32'd0);
        probe("rst_busy", 32'(busy_o), 32'd0);
        probe("rst_result", result_o, 32'd0);

        run("mulh_ss_m1", 2'b01, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, L_B1, 0);
        run("mul_ss_m1", 2'b00, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, L_B1, 0);
        run("mulh_uu_m1", 2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0);
        run("mulhsu", 2'b01, 2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, L_B3, 0);
        run("mul_5x3", 2'b00, 2'b00, 32'd5, 32'd3, 32'h0000_000F, L_B3, 0);
        run("div_ovf", 2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 0);
        run("rem_ovf", 2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35, 0);
        run("div_m7_2", 2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 0);
        run("rem_m7_2", 2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 0);
        run("div_u", 2'b10, 2'b00, 32'd100, 32'd7, 32'd14, 35, 0);
        run("rem_u", 2'b11, 2'b00, 32'd100, 32'd7, 32'd2, 35, 0);
        run("div_zero", 2'b10, 2'b11, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run("rem_zero", 2'b11, 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 0);
        run("stall", 2'b00, 2'b00, 32'd5, 32'd3, 32'h0000_000F, L_B3, 5);

        drive("kill_iter", 2'b10, 2'b00, 32'd1000, 32'd7, 32'd0, 0, 0);
        repeat (10) @(negedge clk);
        probe("kill_iter_busy", 32'(busy_o), 32'd1);
        kill_i = 1;
        @(negedge clk);
        probe("kill_after_busy", 32'(busy_o), 32'd0);
        kill_i = 0;
        #1;
        probe("kill_after_ready", 32'(ready_o), 32'd1);
        repeat (40) @(negedge clk);

        valid_i = 1; kill_i = 1; op_i = 2'b10; op_a_i = 32'd10; op_b_i = 32'd2;
        #1;
        probe("kill_idle_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        probe("kill_idle_busy", 32'(busy_o), 32'd0);
        valid_i = 0; kill_i = 0;

        drive("rst_iter", 2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
        repeat (10) @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        #1;
        probe("rst_iter_ready", 32'(ready_o), 32'd1);
        probe("rst_iter_busy", 32'(busy_o), 32'd0);
        repeat (40) @(negedge clk);

        run("post_rst_div", 2'b10, 2'b00, 32'd100, 32'd7, 32'd14, 35, 0);

        repeat (2) @(negedge clk);
        probe("sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
